// File: rtl/pmem_line_responder.sv
// Cache-line memory responder: holds a line array and answers pmem_read/pmem_write
// requests with a single-cycle pmem_resp pulse after a programmable latency.
module pmem_line_responder #(
  parameter int LINE_BITS     = 256,
  parameter int OFFSET_BITS   = 5,
  parameter int INDEX_BITS    = 6,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 protocol_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count,
  output logic [1:0]           dbg_state
);

  // Handshake: the requester raises pmem_read or pmem_write and holds it (with a
  // stable op) until the one-cycle pmem_resp; dropping it early aborts the request.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam logic [15:0] RD_LAT_M1 = 16'(READ_LATENCY - 1);
  localparam logic [15:0] WR_LAT_M1 = 16'(WRITE_LATENCY - 1);

  logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

  state_t                state_q, state_d;
  logic                  is_write_q, is_write_d;
  logic [INDEX_BITS-1:0] idx_q, idx_d;
  logic [LINE_BITS-1:0]  wdata_q, wdata_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  resp_q, resp_d;
  logic [LINE_BITS-1:0]  rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [15:0]           rd_cnt_q, rd_cnt_d;
  logic [15:0]           wr_cnt_q, wr_cnt_d;
  logic                  req_live;
  logic [15:0]           lat_m1;

  always_comb begin
    state_d    = state_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    resp_d     = 1'b0;
    rdata_d    = '0;
    req_live   = is_write_q ? pmem_write : pmem_read;
    lat_m1     = pmem_write ? WR_LAT_M1 : RD_LAT_M1;

    case (state_q)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          is_write_d = pmem_write;
          idx_d      = pmem_address[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
          if (pmem_write) wdata_d = pmem_wdata;
          if (pmem_read && pmem_write) err_d = 1'b1;
          cnt_d   = lat_m1;
          state_d = (lat_m1 == 16'd0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (!req_live) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt_q == 16'd1) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (is_write_q) wr_cnt_d = wr_cnt_q + 16'd1;
        else            rd_cnt_d = rd_cnt_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are computed on the way into RESP.
    if (state_d == RESP) begin
      resp_d = 1'b1;
      if (!is_write_d) rdata_d = mem[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      resp_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      resp_q     <= resp_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

  // Array contents survive rst; a reset during RESP still blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && is_write_q) mem[idx_q] <= wdata_q;
  end

  assign pmem_resp    = resp_q;
  assign pmem_rdata   = rdata_q;
  assign protocol_err = err_q;
  assign rd_count     = rd_cnt_q;
  assign wr_count     = wr_cnt_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Bench for pmem_line_responder: table of line transactions plus hand-written
// sequences for back-to-back, abort, read+write collision and mid-transaction reset.
module tb_pmem_line_responder;

  localparam int LB = 256;
  localparam int RL = 4;
  localparam int WL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [31:0]   pmem_address = '0;
  logic [LB-1:0] pmem_wdata = '0;
  logic [LB-1:0] pmem_rdata;
  logic          pmem_resp;
  logic          protocol_err;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;
  logic [1:0]    dbg_state;

  pmem_line_responder #(
    .LINE_BITS(LB), .OFFSET_BITS(5), .INDEX_BITS(6),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL)
  ) dut (
    .clk(clk), .rst(rst), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata),
    .pmem_resp(pmem_resp), .protocol_err(protocol_err), .rd_count(rd_count),
    .wr_count(wr_count), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [LB-1:0] exp_q[$];

  typedef struct {
    bit            is_wr;
    logic [31:0]   addr;
    logic [LB-1:0] wdata;
    logic [LB-1:0] exp_rd;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  // Called just after a rising edge (cycle 0); returns just after the edge
  // that ends the resp cycle, with the request lines already dropped.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [LB-1:0] wd, input logic [LB-1:0] exp_rd);
    int lat;
    int exp_lat;
    logic [LB-1:0] exp_v;
    exp_lat = wr ? WL : RL;
    pmem_read = rd;
    pmem_write = wr;
    pmem_address = addr;
    pmem_wdata = wd;
    if (!wr) exp_q.push_back(exp_rd);
    @(negedge clk);
    check("resp_low_cycle0", {255'b0, pmem_resp}, 0);
    check("rdata_zero_cycle0", pmem_rdata, 0);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      if (pmem_resp) lat = c;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL latency: got %0d expected %0d (0 = timeout)", lat, exp_lat);
    end
    if (!wr) begin
      exp_v = exp_q.pop_front();
      if (lat != 0) check("rdata", pmem_rdata, exp_v);
    end
    @(posedge clk);
    #1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
  endtask

  initial begin
    bit saw_resp;

    tbl[0] = '{1'b1, 32'h0000_0040, {32{8'hA5}}, 256'h0};
    tbl[1] = '{1'b0, 32'h0000_0040, 256'h0, {32{8'hA5}}};
    tbl[2] = '{1'b1, 32'h0000_0820, 256'hD1D1_0000_BEEF, 256'h0};
    tbl[3] = '{1'b0, 32'h0000_0020, 256'h0, 256'hD1D1_0000_BEEF};
    tbl[4] = '{1'b1, 32'h0000_07E0, {8{32'h1357_9BDF}}, 256'h0};
    tbl[5] = '{1'b0, 32'hFFFF_FFE0, 256'h0, {8{32'h1357_9BDF}}};
    tbl[6] = '{1'b1, 32'h0000_0040, 256'hC0FFEE, 256'h0};
    tbl[7] = '{1'b0, 32'h0000_005F, 256'h0, 256'hC0FFEE};

    do_reset();
    @(negedge clk);
    check("reset_resp", {255'b0, pmem_resp}, 0);
    check("reset_rdata", pmem_rdata, 0);
    check("reset_err", {255'b0, protocol_err}, 0);
    check("reset_rd_count", {240'b0, rd_count}, 0);
    check("reset_wr_count", {240'b0, wr_count}, 0);
    check("reset_state", {254'b0, dbg_state}, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(!tbl[i].is_wr, tbl[i].is_wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
      idle(1);
      if (i == 1) begin
        check("wr_count_after_first", {240'b0, wr_count}, 1);
        check("rd_count_after_first", {240'b0, rd_count}, 1);
      end
    end
    check("wr_count_table", {240'b0, wr_count}, 4);
    check("rd_count_table", {240'b0, rd_count}, 4);

    // Write-back then load: read rises in the cycle right after the write resp.
    run_txn(1'b0, 1'b1, 32'h0000_0140, 256'hFACE_0A0A, 256'h0);
    run_txn(1'b1, 1'b0, 32'h0000_0140, 256'h0, 256'hFACE_0A0A);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 256'h0, 256'hD1D1_0000_BEEF);
    check("no_err_back_to_back", {255'b0, protocol_err}, 0);
    check("rd_count_b2b", {240'b0, rd_count}, 6);

    // Abort: pmem_read dropped in cycle 2 of a read.
    pmem_read = 1'b1;
    pmem_address = 32'h0000_0040;
    idle(2);
    pmem_read = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (pmem_resp) saw_resp = 1'b1;
    end
    check("abort_no_resp", {255'b0, saw_resp}, 0);
    check("abort_err", {255'b0, protocol_err}, 1);
    check("abort_state_idle", {254'b0, dbg_state}, 0);
    check("abort_rd_count", {240'b0, rd_count}, 6);
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h0000_0040, 256'h0, 256'hC0FFEE);

    // Read and write together: write wins and flags an error.
    do_reset();
    run_txn(1'b1, 1'b1, 32'h0000_0060, 256'h1234, 256'h0);
    idle(1);
    check("both_err", {255'b0, protocol_err}, 1);
    check("both_wr_count", {240'b0, wr_count}, 1);
    check("both_rd_count", {240'b0, rd_count}, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0060, 256'h0, 256'h1234);

    // Reset in cycle 2 of a write to index 5 holding 0xFF.
    run_txn(1'b0, 1'b1, 32'h0000_00A0, 256'hFF, 256'h0);
    do_reset();
    pmem_write = 1'b1;
    pmem_address = 32'h0000_00A0;
    pmem_wdata = 256'h5555;
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    pmem_write = 1'b0;
    saw_resp = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pmem_resp) saw_resp = 1'b1;
    end
    check("rst_mid_no_resp", {255'b0, saw_resp}, 0);
    check("rst_mid_state", {254'b0, dbg_state}, 0);
    check("rst_mid_rd_count", {240'b0, rd_count}, 0);
    check("rst_mid_wr_count", {240'b0, wr_count}, 0);
    check("rst_mid_err", {255'b0, protocol_err}, 0);
    @(posedge clk);
    #1;
    run_txn(1'b1, 1'b0, 32'h0000_00A0, 256'h0, 256'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
